// File: rtl/iir_pkg.sv
// Shared definitions for the comb IIR filter and its inverse.
//   - FSM state encoding for the inverse filter (IDLE, DIV, DONE)
//   - Default widths and coefficients shared by both ends of the filter path
//   - Saturation limit helpers for a signed output of a given width
package iir_pkg;

  localparam int YW_DEF   = 8;  // filtered sample width
  localparam int XW_DEF   = 4;  // raw / recovered sample width
  localparam int COEF_DEF = 7;  // feed-forward coefficient of the IIR
  localparam int TAPS_DEF = 4;  // feedback delay of the IIR

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest positive value of a signed xw-bit number.
  function automatic int sat_hi(input int xw);
    return (1 << (xw - 1)) - 1;
  endfunction

  // Magnitude of the most negative signed xw-bit number.
  function automatic int sat_lo_mag(input int xw);
    return 1 << (xw - 1);
  endfunction

  localparam int X_MAX_DEF = sat_hi(XW_DEF);
  localparam int X_MIN_DEF = -sat_lo_mag(XW_DEF);

endpackage

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned W-bit dividend by a fixed divisor,
// one quotient bit per clock, MSB first.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      load dividend and begin (ignored while busy)
//   dividend   unsigned W-bit dividend, sampled on start
//   busy       a division is in progress
//   done       final step happens on the coming edge; quotient/remainder are
//              complete after that edge and held until the next start
//   quotient   unsigned W-bit quotient
//   remainder  unsigned W-bit remainder (always < DIVISOR)
module seq_restoring_divider #(
  parameter int W       = 8,
  parameter int DIVISOR = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] DIV_V = W'(DIVISOR);

  // work starts as the dividend and is shifted left each step; quotient bits
  // enter at the LSB, so after W steps it holds the full quotient.
  logic [W-1:0]  work;
  logic [W-1:0]  rem;
  logic [CW-1:0] count;
  logic [W-1:0]  trial;
  logic          fits;

  // The partial remainder never reaches DIVISOR < 2^(W-1), so dropping its
  // MSB on the shift loses nothing.
  assign trial = {rem[W-2:0], work[W-1]};
  assign fits  = (trial >= DIV_V);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      work  <= '0;
      rem   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start && !busy) begin
      work  <= dividend;
      rem   <= '0;
      count <= CW'(W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      work <= {work[W-2:0], fits};
      rem  <= fits ? (trial - DIV_V) : trial;
      if (count == '0) begin
        busy <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done      = busy && (count == '0);
  assign quotient  = work;
  assign remainder = rem;

endmodule

// File: rtl/iir_inverse_filter.sv
// Inverse of the comb IIR y[n] = COEF*x[n] + y[n-TAPS] (wrapping YW-bit
// output). Recovers x[n] = (y[n] - y[n-TAPS]) / COEF as a signed XW-bit
// sample, with saturation and an inexact/saturated flag.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   y_in      filtered sample (signed YW), sampled only on accept
//   y_valid   y_in valid
//   y_ready   block can accept y_in (IDLE only, low during reset)
//   x_out     recovered sample (signed XW)
//   x_err     remainder nonzero or result saturated; qualified by x_valid
//   x_valid   x_out/x_err valid (DONE), held until x_ready
//   x_ready   downstream accepts x_out
module iir_inverse_filter
  import iir_pkg::*;
#(
  parameter int YW   = YW_DEF,
  parameter int XW   = XW_DEF,
  parameter int COEF = COEF_DEF,
  parameter int TAPS = TAPS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [YW-1:0] y_in,
  input  logic          y_valid,
  output logic          y_ready,
  output logic [XW-1:0] x_out,
  output logic          x_err,
  output logic          x_valid,
  input  logic          x_ready
);

  localparam logic [YW-1:0] POS_LIM = YW'(sat_hi(XW));
  localparam logic [YW-1:0] NEG_LIM = YW'(sat_lo_mag(XW));
  localparam logic [XW-1:0] X_MAX   = {1'b0, {(XW-1){1'b1}}};
  localparam logic [XW-1:0] X_MIN   = {1'b1, {(XW-1){1'b0}}};

  state_t        state, state_next;
  logic [YW-1:0] d [TAPS];
  logic [YW-1:0] diff;
  logic [YW-1:0] mag;
  logic          neg_q;
  logic          accept;

  logic          div_busy;
  logic          div_done;
  logic [YW-1:0] quotient;
  logic [YW-1:0] remainder;
  logic [XW-1:0] q_low;

  assign y_ready = (state == IDLE) && !div_busy && !rst;
  assign x_valid = (state == DONE);
  assign accept  = y_valid && y_ready;

  // Modular subtraction cancels the IIR's own accumulator wrap.
  assign diff = y_in - d[TAPS-1];
  // Magnitude as unsigned YW bits: the most negative diff maps to 2^(YW-1).
  assign mag  = diff[YW-1] ? (YW'(0) - diff) : diff;

  seq_restoring_divider #(
    .W       (YW),
    .DIVISOR (COEF)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .dividend  (mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE: if (accept)   state_next = DIV;
      DIV:  if (div_done) state_next = DONE;
      DONE: if (x_ready)  state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Delay line and stored sign advance only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is reset element by element because its zero
      // state must match the IIR's zeroed feedback taps.
      for (int k = 0; k < TAPS; k++) begin
        d[k] <= '0;
      end
      neg_q <= 1'b0;
    end else if (accept) begin
      d[0] <= y_in;
      for (int k = 1; k < TAPS; k++) begin
        d[k] <= d[k-1];
      end
      neg_q <= diff[YW-1];
    end
  end

  // Result formation from the divider's held quotient and remainder. These
  // only change after a new accept, so x_out/x_err stay stable through DONE.
  always_comb begin
    q_low = quotient[XW-1:0];
    x_out = q_low;
    x_err = (remainder != '0);
    if (!neg_q && (quotient > POS_LIM)) begin
      x_out = X_MAX;
      x_err = 1'b1;
    end else if (neg_q && (quotient > NEG_LIM)) begin
      x_out = X_MIN;
      x_err = 1'b1;
    end else if (neg_q) begin
      x_out = XW'(0) - q_low;
    end
  end

endmodule

// File: tb/tb_iir_inverse_filter.sv
// Scoreboard bench for iir_inverse_filter: stimulus pushes hand-computed
// expected results; a negedge monitor compares them at each handoff and
// checks latency, stability under backpressure and y_ready in DONE.
module tb_iir_inverse_filter;

  localparam int YW = 8;
  localparam int XW = 4;

  typedef struct {
    int x;
    int err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [YW-1:0] y_in = '0;
  logic          y_valid = 1'b0;
  logic          y_ready;
  logic [XW-1:0] x_out;
  logic          x_err;
  logic          x_valid;
  logic          x_ready = 1'b1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q [$];

  iir_inverse_filter dut (
    .clk     (clk),
    .rst     (rst),
    .y_in    (y_in),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .x_out   (x_out),
    .x_err   (x_err),
    .x_valid (x_valid),
    .x_ready (x_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int accept_cyc = 0;
  bit pending    = 1'b0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (x_valid && !prev_valid) begin
        if (!pending || exp_q.size() == 0) begin
          check("spurious_x_valid", 1, 0);
        end else begin
          check("latency", cyc - accept_cyc, YW);
        end
        pending = 1'b0;
      end
      if (x_valid) begin
        check("y_ready_in_done", int'(y_ready), 0);
        if (exp_q.size() != 0) begin
          check("x_out", $signed(x_out), exp_q[0].x);
          check("x_err", int'(x_err), exp_q[0].err);
          if (x_ready) void'(exp_q.pop_front());
        end
      end
      if (y_valid && y_ready) begin
        accept_cyc = cyc + 1;
        pending    = 1'b1;
      end
      prev_valid = x_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(input int y);
    bit ok = 1'b0;
    y_in    = YW'(y);
    y_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (y_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    y_valid = 1'b0;
    y_in    = YW'($urandom);  // must be ignored until the next accept
  endtask

  task automatic send(input int y, input int ex, input int ee);
    exp_t e;
    e.x   = ex;
    e.err = ee;
    exp_q.push_back(e);
    offer(y);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_y_ready", int'(y_ready), 0);
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_x_err", int'(x_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  int basic_y [5] = '{21, -14, 49, -56, 28};
  int basic_x [5] = '{3, -2, 7, -8, 1};
  // IIR response to a constant x = 7: lanes 49, 98, 147(-109), 196(-60)
  int wrap_y [16] = '{49, 49, 49, 49, 98, 98, 98, 98,
                      -109, -109, -109, -109, -60, -60, -60, -60};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Basic recovery
    for (int i = 0; i < 5; i++) send(basic_y[i], basic_x[i], 0);
    drain();

    // Accumulator wrap is cancelled by modular subtraction
    do_reset();
    for (int i = 0; i < 16; i++) send(wrap_y[i], 7, 0);
    drain();

    // Inexact and saturating results
    do_reset();
    send(10, 1, 1);
    drain();
    do_reset();
    send(126, 7, 1);
    drain();
    do_reset();
    send(-128, -8, 1);
    drain();

    // Backpressure in DONE
    do_reset();
    x_ready = 1'b0;
    send(21, 3, 0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (x_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) check("x_valid_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    y_in    = YW'(-7);
    y_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    x_ready = 1'b1;
    send(-7, -1, 0);
    drain();

    // Reset in the middle of a division
    do_reset();
    offer(49);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("y_ready_after_rst", int'(y_ready), 1);
    repeat (12) @(negedge clk);
    check("no_x_valid_after_abort", int'(x_valid), 0);
    @(posedge clk);
    #1;
    send(21, 3, 0);
    drain();

    // Random y_valid gaps give the same sequence
    do_reset();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      send(basic_y[i], basic_x[i], 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
